// File: rtl/vic20_kbd_pkg.sv
// rtl/vic20_kbd_pkg.sv - shared VIC-20 keyboard types, companion codes and matrix indexing
package vic20_kbd_pkg;

    typedef struct packed {
        logic [2:0] row;
        logic [2:0] col;
    } key_pos_t;

    localparam logic [6:0] KC_LSHIFT = 7'h69;
    localparam logic [6:0] KC_RSHIFT = 7'h6D;
    localparam logic [6:0] KC_LCTRL  = 7'h68;
    localparam logic [6:0] KC_LALT   = 7'h6A;
    localparam logic [6:0] KC_NONE   = 7'h00;

    typedef enum logic [1:0] {
        EMIT_IDLE,
        EMIT_WALK,
        EMIT_PRESENT
    } emit_state_t;

    function automatic logic [5:0] matrix(input int row, input int col);
        return 6'(row * 8 + col);
    endfunction

endpackage

// File: rtl/vic20_revmap.sv
// rtl/vic20_revmap.sv - matrix position to companion code, inverse of the forward keymap
module vic20_revmap
    import vic20_kbd_pkg::*;
(
    input  logic [5:0] idx,
    output logic [6:0] code
);

    key_pos_t pos;
    assign pos = idx;

    // Positions (5,6) '=' and (6,6) up-arrow have no companion code and stay silent.
    always_comb begin
        code = KC_NONE;
        case (matrix(int'(pos.row), int'(pos.col)))
            matrix(0, 0): code = 7'h1E;     matrix(0, 1): code = 7'h20;     matrix(0, 2): code = 7'h22;     matrix(0, 3): code = 7'h24;
            matrix(0, 4): code = 7'h26;     matrix(0, 5): code = 7'h2E;     matrix(0, 6): code = 7'h31;     matrix(0, 7): code = 7'h2A;
            matrix(1, 0): code = 7'h35;     matrix(1, 1): code = 7'h1A;     matrix(1, 2): code = 7'h15;     matrix(1, 3): code = 7'h1C;
            matrix(1, 4): code = 7'h0C;     matrix(1, 5): code = 7'h13;     matrix(1, 6): code = 7'h30;     matrix(1, 7): code = 7'h28;
            matrix(2, 0): code = KC_LCTRL;  matrix(2, 1): code = 7'h04;     matrix(2, 2): code = 7'h07;     matrix(2, 3): code = 7'h0A;
            matrix(2, 4): code = 7'h0D;     matrix(2, 5): code = 7'h0F;     matrix(2, 6): code = 7'h33;     matrix(2, 7): code = 7'h4F;
            matrix(3, 0): code = 7'h29;     matrix(3, 1): code = KC_LSHIFT; matrix(3, 2): code = 7'h1B;     matrix(3, 3): code = 7'h19;
            matrix(3, 4): code = 7'h11;     matrix(3, 5): code = 7'h36;     matrix(3, 6): code = 7'h38;     matrix(3, 7): code = 7'h51;
            matrix(4, 0): code = 7'h2C;     matrix(4, 1): code = 7'h1D;     matrix(4, 2): code = 7'h06;     matrix(4, 3): code = 7'h05;
            matrix(4, 4): code = 7'h10;     matrix(4, 5): code = 7'h37;     matrix(4, 6): code = KC_RSHIFT; matrix(4, 7): code = 7'h3A;
            matrix(5, 0): code = KC_LALT;   matrix(5, 1): code = 7'h16;     matrix(5, 2): code = 7'h09;     matrix(5, 3): code = 7'h0B;
            matrix(5, 4): code = 7'h0E;     matrix(5, 5): code = 7'h34;     matrix(5, 6): code = KC_NONE;   matrix(5, 7): code = 7'h3C;
            matrix(6, 0): code = 7'h14;     matrix(6, 1): code = 7'h08;     matrix(6, 2): code = 7'h17;     matrix(6, 3): code = 7'h18;
            matrix(6, 4): code = 7'h12;     matrix(6, 5): code = 7'h2F;     matrix(6, 6): code = KC_NONE;   matrix(6, 7): code = 7'h3E;
            matrix(7, 0): code = 7'h1F;     matrix(7, 1): code = 7'h21;     matrix(7, 2): code = 7'h23;     matrix(7, 3): code = 7'h25;
            matrix(7, 4): code = 7'h27;     matrix(7, 5): code = 7'h2D;     matrix(7, 6): code = 7'h4A;     matrix(7, 7): code = 7'h40;
            default:      code = KC_NONE;
        endcase
    end

endmodule

// File: rtl/vic20_matrix_scanner.sv
// rtl/vic20_matrix_scanner.sv - VIC-20 matrix scan, per-key debounce and key event emitter
module vic20_matrix_scanner
    import vic20_kbd_pkg::*;
#(
    parameter int SCAN_DIV   = 2000,
    parameter int DEB_FRAMES = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [7:0]  row_n,
    input  logic [7:0]  col_n,
    output logic        key_valid,
    input  logic        key_ready,
    output logic [6:0]  key_code,
    output logic        key_pressed,
    output logic [63:0] matrix_state
);

    localparam int SLOT_W = $clog2(SCAN_DIV);

    logic [7:0]        col_meta, col_sync;
    logic [2:0]        row_idx;
    logic [SLOT_W-1:0] slot_cnt;
    logic [63:0]       raw;
    logic              frame_done;
    logic              scanning, slot_end;
    logic [3:0]        deb_cnt [64];

    // row_n is all-high only in the first cycle out of reset.
    assign scanning = (row_n != 8'hFF);
    assign slot_end = scanning && (slot_cnt == SLOT_W'(SCAN_DIV - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row_n      <= 8'hFF;
            col_meta   <= 8'hFF;
            col_sync   <= 8'hFF;
            row_idx    <= '0;
            slot_cnt   <= '0;
            raw        <= '0;
            frame_done <= 1'b0;
        end else begin
            col_meta   <= col_n;
            col_sync   <= col_meta;
            frame_done <= slot_end && (row_idx == 3'd7);
            if (!scanning) begin
                row_n <= 8'hFE;
            end else if (slot_end) begin
                raw[matrix(int'(row_idx), 0) +: 8] <= ~col_sync;
                slot_cnt <= '0;
                row_idx  <= row_idx + 3'd1;
                row_n    <= ~(8'b1 << (row_idx + 3'd1));
            end else begin
                slot_cnt <= slot_cnt + SLOT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            matrix_state <= '0;
            for (int i = 0; i < 64; i++) deb_cnt[i] <= '0;
        end else if (frame_done) begin
            for (int i = 0; i < 64; i++) begin
                if (raw[i] != matrix_state[i]) begin
                    if (deb_cnt[i] + 4'd1 == 4'(DEB_FRAMES)) begin
                        matrix_state[i] <= raw[i];
                        deb_cnt[i]      <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + 4'd1;
                    end
                end else begin
                    deb_cnt[i] <= '0;
                end
            end
        end
    end

    emit_state_t state, state_nxt;
    logic [5:0]  idx;
    logic [63:0] reported;
    logic        pending;
    logic [6:0]  rev_code;
    logic        differs, emit, handshake, last_idx;

    vic20_revmap u_revmap (
        .idx  (idx),
        .code (rev_code)
    );

    assign differs   = matrix_state[idx] != reported[idx];
    assign emit      = differs && (rev_code != KC_NONE);
    assign handshake = key_valid && key_ready;
    assign last_idx  = (idx == 6'd63);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= EMIT_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMIT_IDLE:    if (pending) state_nxt = EMIT_WALK;
            EMIT_WALK:    if (emit) state_nxt = EMIT_PRESENT;
                          else if (last_idx) state_nxt = EMIT_IDLE;
            EMIT_PRESENT: if (handshake) state_nxt = last_idx ? EMIT_IDLE : EMIT_WALK;
            default:      state_nxt = EMIT_IDLE;
        endcase
    end

    // reported follows the value actually handed out, so press/release strictly alternate.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx         <= '0;
            reported    <= '0;
            pending     <= 1'b0;
            key_valid   <= 1'b0;
            key_code    <= '0;
            key_pressed <= 1'b0;
        end else begin
            if (frame_done)                          pending <= 1'b1;
            else if (state == EMIT_IDLE && pending) pending <= 1'b0;
            case (state)
                EMIT_IDLE: idx <= '0;
                EMIT_WALK: begin
                    if (emit) begin
                        key_valid   <= 1'b1;
                        key_code    <= rev_code;
                        key_pressed <= matrix_state[idx];
                    end else begin
                        if (differs) reported[idx] <= matrix_state[idx];
                        idx <= idx + 6'd1;
                    end
                end
                EMIT_PRESENT: begin
                    if (handshake) begin
                        reported[idx] <= key_pressed;
                        key_valid     <= 1'b0;
                        idx           <= idx + 6'd1;
                    end
                end
                default: idx <= '0;
            endcase
        end
    end

endmodule
